seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a bank of seven-segment
// digits sharing one hex-to-segment decoder. Each digit gets a blank (dead
// time) slot followed by a drive slot. New values are double-buffered and
// committed only at the end of a full scan, so a frame never tears.
//
// Load handshake: load_ready is high whenever no value is pending. A load is
// taken on any rising clk edge where load_valid and load_ready are both high.
// The requester must hold value_in/dp_in stable while load_valid is high and
// load_ready is low. load_ready falls on the cycle after acceptance and rises
// again on the cycle after the end-of-frame commit.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   digit_sel_n,
   output logic [3:0]              nibble_out,
   output logic                    seg_blank,
   output logic                    dp_n,
   output logic                    frame_done,
   output logic                    dbg_state
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int IW      = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [IW-1:0]           r_idx;
   logic [CW-1:0]           r_cnt;
   logic [4*NUM_DIGITS-1:0] r_disp;
   logic [NUM_DIGITS-1:0]   r_disp_dp;
   logic [4*NUM_DIGITS-1:0] r_pend;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic                    r_pending_valid;
   logic                    r_blank_lz;

   logic                    w_blank_done;
   logic                    w_drive_done;
   logic                    w_wrap;
   logic                    w_accept;
   logic [3:0]              w_nibble;
   logic                    w_dp_bit;
   logic                    w_upper_zero;
   logic                    w_lz_blank;

   assign w_blank_done = (r_state == S_BLANK) && (r_cnt == BLANK_LAST);
   assign w_drive_done = (r_state == S_DRIVE) && (r_cnt == DWELL_LAST);
   assign w_wrap       = w_drive_done && (r_idx == IDX_LAST);
   assign w_accept     = load_valid && !r_pending_valid;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_BLANK;
      else        r_state <= w_next_state;
   end

   // Next-state: blank slot then drive slot, each of fixed length.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_BLANK: if (w_blank_done) w_next_state = S_DRIVE;
         S_DRIVE: if (w_drive_done) w_next_state = S_BLANK;
         default: w_next_state = S_BLANK;
      endcase
   end

   // Shared slot counter and digit index; index advances as each drive slot ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else begin
         if (w_blank_done || w_drive_done) r_cnt <= '0;
         else                              r_cnt <= r_cnt + CW'(1);
         if (w_drive_done) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end
   end

   // Double buffer: pending value commits to the display only at frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp          <= '0;
         r_disp_dp       <= '0;
         r_pend          <= '0;
         r_pend_dp       <= '0;
         r_pending_valid <= 1'b0;
      end else if (w_wrap && r_pending_valid) begin
         r_disp          <= r_pend;
         r_disp_dp       <= r_pend_dp;
         r_pending_valid <= 1'b0;
      end else if (w_accept) begin
         r_pend          <= value_in;
         r_pend_dp       <= dp_in;
         r_pending_valid <= 1'b1;
      end
   end

   // Registered copy of blank_lz so outputs depend on flops only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_blank_lz <= 1'b0;
      else        r_blank_lz <= blank_lz;
   end

   // Select current digit's nibble/dp and whether it and all higher digits are zero.
   always_comb begin
      logic zero_run;
      w_nibble     = '0;
      w_dp_bit     = 1'b0;
      w_upper_zero = 1'b0;
      zero_run     = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (r_disp[4*k +: 4] == 4'h0);
         if (r_idx == IW'(k)) begin
            w_nibble     = r_disp[4*k +: 4];
            w_dp_bit     = r_disp_dp[k];
            w_upper_zero = zero_run;
         end
      end
   end

   assign w_lz_blank = r_blank_lz && (r_idx != '0) && w_upper_zero;

   // Output decode: only an unblanked drive slot enables a digit.
   always_comb begin
      digit_sel_n = '1;
      seg_blank   = 1'b1;
      dp_n        = 1'b1;
      nibble_out  = w_nibble;
      frame_done  = w_wrap;
      if ((r_state == S_DRIVE) && !w_lz_blank) begin
         for (int k = 0; k < NUM_DIGITS; k++) digit_sel_n[k] = (r_idx != IW'(k));
         seg_blank = 1'b0;
         dp_n      = ~w_dp_bit;
      end
   end

   assign load_ready = ~r_pending_valid;
   assign dbg_state  = (r_state == S_DRIVE);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: checks seg_scan_ctrl (4 digits, dwell 8, blank 2) against
// a frame-position reference model, a table of display vectors and a few
// hand-written multi-cycle sequences.
module tb_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   value_in = '0;
  logic [3:0]    dp_in = '0;
  logic          load_valid = 1'b0;
  logic          blank_lz = 1'b0;
  logic          load_ready;
  logic [3:0]    digit_sel_n;
  logic [3:0]    nibble_out;
  logic          seg_blank;
  logic          dp_n;
  logic          frame_done;
  logic          dbg_state;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in),
    .load_valid(load_valid), .load_ready(load_ready), .blank_lz(blank_lz),
    .digit_sel_n(digit_sel_n), .nibble_out(nibble_out), .seg_blank(seg_blank),
    .dp_n(dp_n), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard counters and model state
  int          n_checks = 0;
  int          n_fail = 0;
  int          t = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_dp = '0, m_pend_dp = '0;
  logic        m_pending = 1'b0;
  logic        m_acc = 1'b0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] sel_v;
    logic [15:0] nib_v;
    logic [3:0]  dpn_v;
    logic [3:0]  blk_v;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s t=%0d: wait bound expired", name, t);
  endtask

  // Reference: outputs follow from position in the frame and the committed value.
  task automatic check_model();
    int f, d, ph;
    logic drive, lz, active;
    logic [3:0] sel;
    f = t % FRAME;
    d = f / SLOT;
    ph = f % SLOT;
    drive = (ph >= BL);
    lz = blank_lz && (d != 0) && ((m_disp >> (4 * d)) == 16'h0);
    active = drive && !lz;
    sel = active ? ~(4'b0001 << d) : 4'hF;
    chk("digit_sel_n", 32'(digit_sel_n), 32'(sel));
    chk("nibble_out", 32'(nibble_out), 32'(m_disp[4*d +: 4]));
    chk("seg_blank", 32'(seg_blank), 32'(!active));
    chk("dp_n", 32'(dp_n), active ? 32'(!m_dp[d]) : 32'd1);
    chk("frame_done", 32'(frame_done), 32'(f == FRAME - 1));
    chk("load_ready", 32'(load_ready), 32'(!m_pending));
    chk("dbg_state", 32'(dbg_state), 32'(drive));
  endtask

  task automatic model_update();
    int f;
    f = t % FRAME;
    m_acc = load_valid && !m_pending;
    if (f == FRAME - 1 && m_pending) begin
      m_disp = m_pend;
      m_dp = m_pend_dp;
      m_pending = 1'b0;
    end else if (m_acc) begin
      m_pend = value_in;
      m_pend_dp = dp_in;
      m_pending = 1'b1;
    end
    t++;
  endtask

  task automatic model_reset();
    t = 0;
    m_disp = '0; m_dp = '0; m_pend = '0; m_pend_dp = '0;
    m_pending = 1'b0; m_acc = 1'b0;
  endtask

  // driver tasks
  task automatic step();
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_to(input int pos);
    bit hit;
    hit = 0;
    for (int i = 0; i <= FRAME; i++) begin
      if (t % FRAME == pos) begin hit = 1; break; end
      step();
    end
    if (!hit) timeout_fail("run_to");
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    bit hit;
    hit = 0;
    load_valid = 1'b1; value_in = v; dp_in = dp;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (m_acc) begin hit = 1; break; end
    end
    load_valid = 1'b0;
    if (!hit) timeout_fail("load_accept");
  endtask

  task automatic wait_commit();
    bit hit;
    hit = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (!m_pending && (t % FRAME == 0)) begin hit = 1; break; end
      step();
    end
    if (!hit) timeout_fail("wait_commit");
  endtask

  // blank_lz is only changed at the start of a blank slot
  task automatic set_lz(input logic v);
    for (int i = 0; i < SLOT; i++) begin
      if (t % SLOT == 0) break;
      step();
    end
    blank_lz = v;
  endtask

  function automatic logic [15:0] rand_val();
    int n;
    logic [15:0] r, mask;
    n = $urandom_range(0, 4);
    r = 16'($urandom);
    mask = (n == 4) ? 16'hFFFF : 16'((1 << (4 * n)) - 1);
    return r & mask;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel"}, 32'(digit_sel_n), 32'hF);
    chk({tag, "_blank"}, 32'(seg_blank), 32'd1);
    chk({tag, "_dp_n"}, 32'(dp_n), 32'd1);
    chk({tag, "_nibble"}, 32'(nibble_out), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    bit hit;
    vec_t v;

    vecs[0] = '{16'h1A3F, 4'b0100, 1'b0, 16'h7BDE, 16'h1A3F, 4'b1011, 4'b0000};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 16'hFFDE, 16'h0050, 4'b1111, 4'b1100};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'hFFFE, 16'h0000, 4'b1111, 4'b1110};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, 16'h7BDE, 16'h0000, 4'b1111, 4'b0000};
    vecs[4] = '{16'h1234, 4'b1001, 1'b1, 16'h7BDE, 16'h1234, 4'b0110, 4'b0000};
    vecs[5] = '{16'h0F00, 4'b1000, 1'b1, 16'hFBDE, 16'h0F00, 4'b1111, 4'b1000};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // scan timing after reset
    chk("rel_t0_sel", 32'(digit_sel_n), 32'hF);
    step();
    chk("rel_t1_sel", 32'(digit_sel_n), 32'hF);
    step();
    chk("rel_t2_sel", 32'(digit_sel_n), 32'hE);
    chk("rel_t2_nib", 32'(nibble_out), 32'h0);
    run_to(SLOT);
    chk("rel_t10_sel", 32'(digit_sel_n), 32'hF);
    step(); step();
    chk("rel_t12_sel", 32'(digit_sel_n), 32'hD);

    // frame period measured between two frame_done pulses
    t1 = -1; t2 = -1;
    for (int i = 0; i < 3 * FRAME && t2 < 0; i++) begin
      if (frame_done) begin
        if (t1 < 0) t1 = t; else t2 = t;
      end
      step();
    end
    if (t2 < 0) timeout_fail("frame_period");
    else chk("frame_period", 32'(t2 - t1), 32'(FRAME));

    // table-driven display vectors
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      load(v.value, v.dp);
      wait_commit();
      blank_lz = v.lz;
      for (int k = 0; k < ND; k++) begin
        run_to(SLOT * k + BL + 3);
        chk($sformatf("tbl%0d_sel%0d", i, k), 32'(digit_sel_n), 32'(v.sel_v[4*k +: 4]));
        chk($sformatf("tbl%0d_nib%0d", i, k), 32'(nibble_out), 32'(v.nib_v[4*k +: 4]));
        chk($sformatf("tbl%0d_dpn%0d", i, k), 32'(dp_n), 32'(v.dpn_v[k]));
        chk($sformatf("tbl%0d_blk%0d", i, k), 32'(seg_blank), 32'(v.blk_v[k]));
      end
    end

    // second load held off until the cycle after the commit
    set_lz(1'b0);
    load(16'h1111, 4'h0);
    load(16'h2222, 4'h0);
    chk("hold_accept_pos", 32'(t % FRAME), 32'd1);
    run_to(BL + 3);
    chk("hold_first_frame_d0", 32'(nibble_out), 32'h1);
    run_to(3 * SLOT + BL + 3);
    chk("hold_first_frame_d3", 32'(nibble_out), 32'h1);
    wait_commit();
    run_to(3 * SLOT + BL + 3);
    chk("hold_second_frame_nib", 32'(nibble_out), 32'h2);
    chk("hold_second_frame_sel", 32'(digit_sel_n), 32'h7);

    // load accepted on the frame_done cycle commits one frame later
    run_to(FRAME - 1);
    chk("wrapload_fd", 32'(frame_done), 32'd1);
    load_valid = 1'b1; value_in = 16'h0BEE; dp_in = 4'h0;
    step();
    load_valid = 1'b0;
    chk("wrapload_ready_low", 32'(load_ready), 32'd0);
    run_to(BL + 3);
    chk("wrapload_old_kept", 32'(nibble_out), 32'h2);
    wait_commit();
    run_to(BL + 3);
    chk("wrapload_new", 32'(nibble_out), 32'hE);

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      load_valid = ($urandom_range(0, 7) == 0);
      value_in = rand_val();
      dp_in = 4'($urandom);
      if ((t % SLOT == 0) && ($urandom_range(0, 3) == 0)) blank_lz = 1'($urandom);
      step();
    end
    load_valid = 1'b0;

    // asynchronous reset during drive of digit 2 with a load pending
    set_lz(1'b0);
    run_to(0);
    load(16'h5A5A, 4'hF);
    run_to(2 * SLOT + BL + 3);
    chk("arst_pre_sel", 32'(digit_sel_n), 32'hB);
    chk("arst_pre_pending", 32'(load_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_to(BL + 3);
    chk("arst_after_sel", 32'(digit_sel_n), 32'hE);
    chk("arst_after_nib", 32'(nibble_out), 32'h0);
    chk("arst_after_ready", 32'(load_ready), 32'd1);
    hit = 0;
    for (int i = 0; i < 2 * FRAME; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
